// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer for a multi-cycle (stalling) instruction memory.
// It owns the PC and issues one read per instruction. It buffers the returned
// word until decode accepts it, applies branch redirects, squashes stale
// in-flight reads, and parks the front end on HALT.
// Optional feature: define FETCH_TIMEOUT_EN to bound the WAIT state. When the
// bound is reached, the sticky mem_err output is set and the front end is
// forced into HALT.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ISSUE | read request driven at PC; repeated while mem_stall is high
// WAIT  | request accepted, waiting for mem_done (data dropped if squashed)
// HOLD  | word presented to decode; the next read is issued on the same
//       | cycle the word is consumed (gives the 2-cycle minimum latency)
// HALT  | front end parked; left only by branch or reset

module fetch_ctrl #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800,
  parameter int               TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_PC,
  input  logic             halt,
  input  logic             mem_stall,
  input  logic             mem_done,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] instruc,
  output logic             instr_valid,
  output logic [WIDTH-1:0] seq_PC,
  output logic             halted,
  output logic             mem_err
);

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic             valid_q, valid_d;
  logic             squash_q, squash_d;
  logic             halted_q, halted_d;
  logic             consume;
  logic             hold_issue;
  logic             timeout_hit;

  assign pc_inc     = pc_q + WIDTH'(2);
  assign consume    = (state_q == S_HOLD) && !pipe_stall;
  // The next read overlaps the accept cycle, unless decode is halting
  // or a redirect is about to replace the PC.
  assign hold_issue = consume && !halt && !branch;

  // Read request is suppressed while reset is asserted.
  assign mem_rd      = rst && ((state_q == S_ISSUE) || hold_issue);
  assign mem_addr    = pc_q;
  assign instruc     = valid_q ? instr_q : NOP_INSTR;
  assign instr_valid = valid_q;
  assign seq_PC      = seq_q;
  assign halted      = halted_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Counts consecutive WAIT cycles. It restarts at zero on every entry to
  // WAIT and saturates so that a redirect on the final cycle cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wait_cnt_q <= '0;
    else if (state_q != S_WAIT) wait_cnt_q <= '0;
    else if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q == S_WAIT) && !branch && !mem_done &&
                       (wait_cnt_q >= CNT_LAST);

  // Sticky error flag; it is cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // Next-state and datapath update. A branch overrides everything else.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    seq_d    = seq_q;
    valid_d  = valid_q;
    squash_d = squash_q;
    halted_d = halted_q;
    if (branch) begin
      pc_d     = branch_PC & ~WIDTH'(1);
      valid_d  = 1'b0;
      halted_d = 1'b0;
      if ((state_q == S_WAIT) && !mem_done) begin
        squash_d = 1'b1;
      end else begin
        squash_d = 1'b0;
        state_d  = S_ISSUE;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (!mem_stall) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_ISSUE;
            end else begin
              instr_d = mem_data;
              valid_d = 1'b1;
              seq_d   = pc_inc;
              pc_d    = pc_inc;
              state_d = S_HOLD;
            end
          end else if (timeout_hit) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        end
        S_HOLD: begin
          if (consume) begin
            valid_d = 1'b0;
            if (halt) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else if (mem_stall) begin
              state_d = S_ISSUE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      seq_q    <= RESET_PC + WIDTH'(2);
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      seq_q    <= seq_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
      halted_q <= halted_d;
    end
  end

endmodule
